mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store unit. Consumes the EX/MEM latch outputs (address, store data, size, read/write).
//  Runs a req/ack transaction on the data-memory bus and stalls the pipeline until the transaction completes.
//  Aligns and extends load data, builds byte strobes for stores, and flags misaligned and timed-out accesses.
//  Its outputs feed the MEM/WB latch and the exception unit.
// PARAMETERS
//  TIMEOUT  255  max cycles BUSY waits for dmem_ack before declaring an access fault (1..2^CNT_W-1)
//  CNT_W    8    width of the timeout counter
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   reset, asynchronous, active-high
//  ALUO_MEM       in   32  effective address
//  Datao_MEM      in   32  store data (rs2)
//  WR_MEM         in   1   store request
//  mem_r_MEM      in   1   load request
//  u_b_h_w_MEM    in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  isFlushed      in   1   MEM slot holds a bubble; ignore WR/mem_r
//  dmem_req       out  1   bus request, held until ack
//  dmem_we        out  1   1=write, 0=read; valid while dmem_req
//  dmem_addr      out  32  {ALUO_MEM[31:2],2'b00}
//  dmem_wdata     out  32  store data replicated by size (B: {4{b}}, H: {2{h}}, W: word)
//  dmem_wstrb     out  4   byte enables (0 on reads)
//  dmem_rdata     in   32  read word, valid with dmem_ack
//  dmem_ack       in   1   one-cycle completion pulse
//  stall_mem      out  1   hold PC, IF/ID, ID/EX, EX/MEM (EN low)
//  load_data      out  32  aligned/extended load result (registered)
//  load_valid     out  1   load_data valid this cycle (1-cycle pulse, DONE state)
//  exp_ld_misalign out 1   load misaligned (combinational)
//  exp_st_misalign out 1   store misaligned (combinational)
//  exp_access_fault out 1  bus timeout, 1-cycle pulse in DONE
// BEHAVIOUR
//  - access = (WR_MEM|mem_r_MEM) & ~isFlushed. WR_MEM has priority if both are set (treat as a store).
//  - misalign = H/HU with addr[0]=1, or W with addr[1:0]!=0. exp_*_misalign = access & misalign.
//  - A misaligned access issues no bus cycle and asserts no stall.
//  - FSM states IDLE, BUSY, DONE. Reset: IDLE. All registered outputs are 0 at reset: dmem_req, dmem_we,
//    load_data, load_valid, exp_access_fault, and the counter.
//  - IDLE:
//    - access & ~misalign: register req=1, we=WR_MEM, wstrb, wdata; clear the counter; go to BUSY.
//    - otherwise: stay in IDLE.
//  - BUSY:
//    - dmem_req=1 held, with address/data stable.
//    - On ack: req=0; if a load, load_data<=extend(select(rdata)); go to DONE.
//    - Else if counter==TIMEOUT-1: req=0; set fault flag; go to DONE.
//    - Else: counter++.
//  - DONE (exactly 1 cycle): load_valid=1 for a load with no fault; exp_access_fault=fault flag. Next state IDLE.
//  - stall_mem = access & ~misalign & (state!=DONE). This is combinational. With ack in the first BUSY cycle
//    the pipeline advances on the 3rd cycle of the access.
//  - Byte select uses addr[1:0], half select uses addr[1]. B/H are sign-extended; BU/HU are zero-extended.
//  - wstrb: B = 1<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111.
//  - EX/MEM inputs are stable while stall_mem=1. The unit does not re-sample them in BUSY.
//  - An ack arriving in IDLE or DONE is ignored. An ack in the same cycle as the timeout takes precedence
//    (no fault).
//  - Async rst mid-transaction returns to IDLE, drops req immediately, and discards the result.
// TESTING
//  1 LW addr 0x100, ack 2 cycles after req, rdata 0xDEADBEEF -> stall 4 cycles, load_data=0xDEADBEEF, load_valid 1 cycle
//  2 LB addr 0x103, rdata 0x80112233 -> 0xFFFFFF80; LBU -> 0x00000080; LHU addr 0x102 -> 0x00008011
//  3 SB addr 0x101 data 0x000000AB -> wstrb=0010, wdata=0xABABABAB, we=1; SH 0x102 -> wstrb=1100
//  4 LW addr 0x102 -> exp_ld_misalign=1, no dmem_req, stall_mem=0; SH addr 0x1 -> exp_st_misalign=1
//  5 TIMEOUT=4, never ack -> req drops after 4 BUSY cycles, exp_access_fault 1 cycle, load_valid=0, stall released
//  6 Back-to-back LW/SW, isFlushed bubble (no req), rst asserted during BUSY -> req=0 immediately, state IDLE

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: req/ack data-memory bus master with load align/extend, store strobes, misalign and timeout flags.
// Stalls the pipeline from the IDLE cycle of an access through BUSY; releases it in the single DONE cycle.
module mem_access_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUO_MEM,
  input  logic [31:0] Datao_MEM,
  input  logic        WR_MEM,
  input  logic        mem_r_MEM,
  input  logic [2:0]  u_b_h_w_MEM,
  input  logic        isFlushed,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_mem,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        exp_ld_misalign,
  output logic        exp_st_misalign,
  output logic        exp_access_fault
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             is_load_q, is_load_nxt;
  logic             req_nxt, we_nxt, lv_nxt, fault_nxt;
  logic [3:0]       wstrb_nxt;
  logic [31:0]      wdata_nxt, ld_nxt;

  logic             access, misalign, is_byte, is_half, is_word;
  logic [3:0]       wstrb_c;
  logic [31:0]      wdata_c, shifted_rdata, ext_c;
  logic [15:0]      half_sel;
  logic [7:0]       byte_sel;

  // Size decode: funct3[1:0] carries the width, funct3[2] selects zero-extension.
  assign is_byte  = (u_b_h_w_MEM[1:0] == 2'b00);
  assign is_half  = (u_b_h_w_MEM[1:0] == 2'b01);
  assign is_word  = ~is_byte & ~is_half;

  assign access   = (WR_MEM | mem_r_MEM) & ~isFlushed;
  assign misalign = (is_half & ALUO_MEM[0]) | (is_word & (ALUO_MEM[1:0] != 2'b00));

  assign exp_ld_misalign = access & misalign & ~WR_MEM;
  assign exp_st_misalign = access & misalign & WR_MEM;
  assign stall_mem       = access & ~misalign & (state != DONE);
  assign dmem_addr       = {ALUO_MEM[31:2], 2'b00};

  always_comb begin
    wstrb_c = 4'b1111;
    wdata_c = Datao_MEM;
    if (is_byte) begin
      wstrb_c = 4'b0001 << ALUO_MEM[1:0];
      wdata_c = {4{Datao_MEM[7:0]}};
    end else if (is_half) begin
      wstrb_c = 4'b0011 << ALUO_MEM[1:0];
      wdata_c = {2{Datao_MEM[15:0]}};
    end
  end

  // Addresses stay stable through BUSY, so the lane select can use them directly at ack time.
  assign shifted_rdata = dmem_rdata >> {ALUO_MEM[1:0], 3'b000};
  assign byte_sel      = shifted_rdata[7:0];
  assign half_sel      = ALUO_MEM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    ext_c = dmem_rdata;
    if (is_byte) begin
      ext_c = u_b_h_w_MEM[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    end else if (is_half) begin
      ext_c = u_b_h_w_MEM[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_nxt     = dmem_req;
    we_nxt      = dmem_we;
    wstrb_nxt   = dmem_wstrb;
    wdata_nxt   = dmem_wdata;
    ld_nxt      = load_data;
    lv_nxt      = 1'b0;
    fault_nxt   = 1'b0;
    cnt_nxt     = cnt;
    is_load_nxt = is_load_q;
    case (state)
      IDLE: begin
        if (access && !misalign) begin
          req_nxt     = 1'b1;
          we_nxt      = WR_MEM;
          wstrb_nxt   = WR_MEM ? wstrb_c : 4'b0000;
          wdata_nxt   = WR_MEM ? wdata_c : 32'h0;
          is_load_nxt = ~WR_MEM;
          cnt_nxt     = '0;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        // An ack landing on the final timeout cycle still completes normally.
        if (dmem_ack) begin
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          wstrb_nxt = 4'b0000;
          lv_nxt    = is_load_q;
          if (is_load_q) begin
            ld_nxt = ext_c;
          end
          state_nxt = DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          wstrb_nxt = 4'b0000;
          fault_nxt = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_wstrb       <= 4'b0000;
      dmem_wdata       <= 32'h0;
      load_data        <= 32'h0;
      load_valid       <= 1'b0;
      exp_access_fault <= 1'b0;
      cnt              <= '0;
      is_load_q        <= 1'b0;
    end else begin
      dmem_req         <= req_nxt;
      dmem_we          <= we_nxt;
      dmem_wstrb       <= wstrb_nxt;
      dmem_wdata       <= wdata_nxt;
      load_data        <= ld_nxt;
      load_valid       <= lv_nxt;
      exp_access_fault <= fault_nxt;
      cnt              <= cnt_nxt;
      is_load_q        <= is_load_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, timeout, back-to-back, bubbles and reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ALUO_MEM = '0, Datao_MEM = '0, dmem_rdata = '0;
  logic        WR_MEM = 1'b0, mem_r_MEM = 1'b0, isFlushed = 1'b0, dmem_ack = 1'b0;
  logic [2:0]  u_b_h_w_MEM = 3'b000;
  logic        dmem_req, dmem_we, stall_mem, load_valid;
  logic        exp_ld_misalign, exp_st_misalign, exp_access_fault;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic [3:0]  dmem_wstrb;

  int errors = 0;
  int checks = 0;

  // Results captured by do_access
  int          stall_cycles, req_cycles;
  logic        done_lv, done_fault, done_req, post_lv, post_fault;
  logic [31:0] done_ld, snap_addr, snap_wdata;
  logic [3:0]  snap_wstrb;
  logic        snap_we;

  mem_access_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ALUO_MEM(ALUO_MEM), .Datao_MEM(Datao_MEM), .WR_MEM(WR_MEM),
    .mem_r_MEM(mem_r_MEM), .u_b_h_w_MEM(u_b_h_w_MEM), .isFlushed(isFlushed),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall_mem(stall_mem),
    .load_data(load_data), .load_valid(load_valid), .exp_ld_misalign(exp_ld_misalign),
    .exp_st_misalign(exp_st_misalign), .exp_access_fault(exp_access_fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_op();
    WR_MEM = 1'b0; mem_r_MEM = 1'b0; isFlushed = 1'b0;
  endtask

  // Presents one op, acks on the (ack_delay+1)-th req cycle (never if negative), runs to DONE and one cycle beyond.
  task automatic do_access(input logic [31:0] a, input logic [31:0] d, input logic wr, input logic rd,
                           input logic [2:0] f3, input int ack_delay, input logic [31:0] rdat);
    bit seen = 0;
    bit timed_out = 0;
    ALUO_MEM = a; Datao_MEM = d; WR_MEM = wr; mem_r_MEM = rd; u_b_h_w_MEM = f3; isFlushed = 1'b0;
    stall_cycles = 0; req_cycles = 0;
    #1;
    while (stall_mem === 1'b1) begin
      if (stall_cycles > 40) begin
        timed_out = 1;
        break;
      end
      stall_cycles++;
      if (dmem_req === 1'b1) begin
        req_cycles++;
        if (!seen) begin
          seen = 1;
          snap_addr = dmem_addr; snap_wdata = dmem_wdata; snap_wstrb = dmem_wstrb; snap_we = dmem_we;
        end
        if (ack_delay >= 0 && req_cycles == ack_delay + 1) begin
          dmem_ack = 1'b1; dmem_rdata = rdat;
        end
      end
      @(posedge clk);
      #1;
      dmem_ack = 1'b0; dmem_rdata = '0;
      #1;
    end
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL access_bound: stall_mem still %b after %0d cycles, want release", stall_mem, stall_cycles);
    end
    done_lv = load_valid; done_ld = load_data; done_fault = exp_access_fault; done_req = dmem_req;
    step();
    clear_op();
    post_lv = load_valid; post_fault = exp_access_fault;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", dmem_req); end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", dmem_we); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL rst_ld: got %h want 0", load_data); end
    checks++; if ({load_valid, exp_access_fault, stall_mem} !== 3'b000) begin
      errors++; $display("FAIL rst_flags: got %b want 000", {load_valid, exp_access_fault, stall_mem}); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_lw();
    do_access(32'h100, 32'h0, 1'b0, 1'b1, 3'b010, 2, 32'hDEADBEEF);
    checks++; if (stall_cycles != 4) begin errors++; $display("FAIL lw_stall: got %0d want 4", stall_cycles); end
    checks++; if (req_cycles != 3) begin errors++; $display("FAIL lw_req: got %0d want 3", req_cycles); end
    checks++; if ({snap_we, snap_wstrb, snap_addr} !== {1'b0, 4'b0000, 32'h100}) begin
      errors++; $display("FAIL lw_bus: got we=%b strb=%b addr=%h want 0 0000 00000100", snap_we, snap_wstrb, snap_addr); end
    checks++; if (done_ld !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", done_ld); end
    checks++; if ({done_lv, done_req, post_lv} !== 3'b100) begin
      errors++; $display("FAIL lw_valid: got lv=%b req=%b next_lv=%b want 1 0 0", done_lv, done_req, post_lv); end
  endtask

  task automatic test_load_extend();
    logic [31:0] addrs [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
    logic [2:0]  fns   [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b001};
    logic [31:0] exps  [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00008011, 32'hFFFF8011, 32'h00002233};
    for (int i = 0; i < 5; i++) begin
      do_access(addrs[i], 32'h0, 1'b0, 1'b1, fns[i], 0, 32'h80112233);
      checks++; if (done_ld !== exps[i] || done_lv !== 1'b1) begin
        errors++; $display("FAIL ld_ext[%0d]: got %h lv=%b want %h lv=1", i, done_ld, done_lv, exps[i]); end
    end
    checks++; if (stall_cycles != 2) begin errors++; $display("FAIL ld_ack0_stall: got %0d want 2", stall_cycles); end
  endtask

  task automatic test_store();
    do_access(32'h101, 32'h000000AB, 1'b1, 1'b0, 3'b000, 0, 32'h0);
    checks++; if ({snap_we, snap_wstrb, snap_wdata} !== {1'b1, 4'b0010, 32'hABABABAB}) begin
      errors++; $display("FAIL sb: got we=%b strb=%b wdata=%h want 1 0010 abababab", snap_we, snap_wstrb, snap_wdata); end
    checks++; if (done_lv !== 1'b0) begin errors++; $display("FAIL sb_lv: got %b want 0", done_lv); end
    do_access(32'h102, 32'h00001234, 1'b1, 1'b0, 3'b001, 1, 32'h0);
    checks++; if ({snap_wstrb, snap_wdata, snap_addr} !== {4'b1100, 32'h12341234, 32'h100}) begin
      errors++; $display("FAIL sh: got strb=%b wdata=%h addr=%h want 1100 12341234 00000100", snap_wstrb, snap_wdata, snap_addr); end
    do_access(32'h104, 32'hCAFEF00D, 1'b1, 1'b1, 3'b010, 0, 32'h0);
    checks++; if ({snap_we, snap_wstrb, snap_wdata} !== {1'b1, 4'b1111, 32'hCAFEF00D}) begin
      errors++; $display("FAIL sw_prio: got we=%b strb=%b wdata=%h want 1 1111 cafef00d", snap_we, snap_wstrb, snap_wdata); end
  endtask

  task automatic test_misalign();
    ALUO_MEM = 32'h102; WR_MEM = 1'b0; mem_r_MEM = 1'b1; u_b_h_w_MEM = 3'b010;
    #1;
    checks++; if ({exp_ld_misalign, exp_st_misalign, stall_mem} !== 3'b100) begin
      errors++; $display("FAIL lw_mis: got ld=%b st=%b stall=%b want 1 0 0", exp_ld_misalign, exp_st_misalign, stall_mem); end
    step();
    step();
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL lw_mis_req: got %b want 0", dmem_req); end
    ALUO_MEM = 32'h1; WR_MEM = 1'b1; mem_r_MEM = 1'b0; u_b_h_w_MEM = 3'b001;
    #1;
    checks++; if ({exp_ld_misalign, exp_st_misalign, stall_mem} !== 3'b010) begin
      errors++; $display("FAIL sh_mis: got ld=%b st=%b stall=%b want 0 1 0", exp_ld_misalign, exp_st_misalign, stall_mem); end
    isFlushed = 1'b1;
    #1;
    checks++; if ({exp_ld_misalign, exp_st_misalign} !== 2'b00) begin
      errors++; $display("FAIL mis_flushed: got ld=%b st=%b want 0 0", exp_ld_misalign, exp_st_misalign); end
    step();
    clear_op();
  endtask

  task automatic test_timeout();
    do_access(32'h200, 32'h0, 1'b0, 1'b1, 3'b010, -1, 32'h0);
    checks++; if (req_cycles != 4 || stall_cycles != 5) begin
      errors++; $display("FAIL to_cycles: got req=%0d stall=%0d want 4 5", req_cycles, stall_cycles); end
    checks++; if ({done_fault, done_lv, done_req} !== 3'b100) begin
      errors++; $display("FAIL to_flags: got fault=%b lv=%b req=%b want 1 0 0", done_fault, done_lv, done_req); end
    checks++; if (post_fault !== 1'b0) begin errors++; $display("FAIL to_pulse: got %b want 0", post_fault); end
    do_access(32'h204, 32'h0, 1'b0, 1'b1, 3'b010, 3, 32'h55AA33CC);
    checks++; if ({done_fault, done_lv, done_ld} !== {1'b0, 1'b1, 32'h55AA33CC}) begin
      errors++; $display("FAIL to_ack_race: got fault=%b lv=%b ld=%h want 0 1 55aa33cc", done_fault, done_lv, done_ld); end
  endtask

  task automatic test_back_to_back();
    do_access(32'h300, 32'h0, 1'b0, 1'b1, 3'b010, 0, 32'h01020304);
    checks++; if (done_ld !== 32'h01020304) begin errors++; $display("FAIL b2b_lw: got %h want 01020304", done_ld); end
    do_access(32'h306, 32'h0000BEEF, 1'b1, 1'b0, 3'b001, 0, 32'h0);
    checks++; if ({stall_cycles, snap_wstrb} !== {32'd2, 4'b1100}) begin
      errors++; $display("FAIL b2b_sw: got stall=%0d strb=%b want 2 1100", stall_cycles, snap_wstrb); end
    ALUO_MEM = 32'h400; WR_MEM = 1'b1; mem_r_MEM = 1'b1; u_b_h_w_MEM = 3'b010; isFlushed = 1'b1;
    #1;
    checks++; if (stall_mem !== 1'b0) begin errors++; $display("FAIL bubble_stall: got %b want 0", stall_mem); end
    step();
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL bubble_req: got %b want 0", dmem_req); end
    clear_op();
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    step();
    dmem_ack = 1'b0; dmem_rdata = '0;
    step();
    checks++; if ({load_valid, dmem_req, load_data} !== {1'b0, 1'b0, 32'h01020304}) begin
      errors++; $display("FAIL idle_ack: got lv=%b req=%b ld=%h want 0 0 01020304", load_valid, dmem_req, load_data); end
  endtask

  task automatic test_reset_busy();
    ALUO_MEM = 32'h500; WR_MEM = 1'b0; mem_r_MEM = 1'b1; u_b_h_w_MEM = 3'b010;
    step();
    step();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rb_req_pre: got %b want 1", dmem_req); end
    rst = 1'b1;
    #1;
    checks++; if ({dmem_req, load_valid, load_data} !== {1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL rb_req_drop: got req=%b lv=%b ld=%h want 0 0 0", dmem_req, load_valid, load_data); end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rb_restart: got %b want 1", dmem_req); end
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    step();
    dmem_ack = 1'b0; dmem_rdata = '0;
    checks++; if ({load_valid, stall_mem, load_data} !== {1'b1, 1'b0, 32'h12345678}) begin
      errors++; $display("FAIL rb_done: got lv=%b stall=%b ld=%h want 1 0 12345678", load_valid, stall_mem, load_data); end
    step();
    clear_op();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_extend();
    test_store();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
